// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 master, 8-bit MSB-first frames, cs_n held low across a tx_last-terminated burst
module spi_master #(
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       sclk,
    output logic       cs_n,
    output logic       mosi,
    input  logic       miso
);

    localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_B = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_P) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT, S_WAIT, S_HOLD, S_GAP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    tog_q, tog_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          last_q, last_d;
    logic          sclk_q, sclk_d;
    logic          cs_n_q, cs_n_d;
    logic          mosi_q, mosi_d;
    logic          rx_valid_q, rx_valid_d;
    logic          tx_ready_q, tx_ready_d;

    logic accept, half_done, byte_done, rising, falling;

    assign accept    = tx_valid && tx_ready_q;
    assign half_done = (cnt_q == CW'(CLK_DIV - 1));
    assign byte_done = (state_q == S_SHIFT) && half_done && (tog_q == 5'd15);
    assign rising    = (state_q == S_SHIFT) && half_done && !sclk_q;
    assign falling   = (state_q == S_SHIFT) && half_done && sclk_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            tog_q      <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            last_q     <= 1'b0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tog_q      <= tog_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            last_q     <= last_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_SETUP;
            S_SETUP: if (cnt_q == CW'(CS_SETUP - 1)) state_d = S_SHIFT;
            S_SHIFT: if (byte_done) state_d = last_q ? S_HOLD : S_WAIT;
            S_WAIT:  if (accept) state_d = S_SHIFT;
            S_HOLD:  if (cnt_q == CW'(CS_HOLD - 1)) state_d = S_GAP;
            S_GAP:   if (cnt_q == CW'(CS_IDLE - 1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        // Counters restart on every state entry and each sclk half-period, so they never wrap.
        cnt_d = cnt_q + CW'(1);
        if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_WAIT) ||
            ((state_q == S_SHIFT) && half_done)) begin
            cnt_d = '0;
        end

        tog_d = tog_q;
        if ((state_q != S_SHIFT) || (state_d != S_SHIFT)) begin
            tog_d = '0;
        end else if (half_done) begin
            tog_d = tog_q + 5'd1;
        end

        sclk_d = 1'b0;
        if (state_q == S_SHIFT) begin
            sclk_d = half_done ? ~sclk_q : sclk_q;
        end

        tx_shift_d = tx_shift_q;
        last_d     = last_q;
        mosi_d     = mosi_q;
        if (accept) begin
            tx_shift_d = tx_data;
            last_d     = tx_last;
            mosi_d     = tx_data[7];
        end else if (falling && (tog_q != 5'd15)) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
            mosi_d     = tx_shift_q[6];
        end
        if (state_d == S_GAP) begin
            mosi_d = 1'b0;
        end

        rx_shift_d = rising ? {rx_shift_q[6:0], miso} : rx_shift_q;
        rx_data_d  = byte_done ? rx_shift_q : rx_data_q;
        rx_valid_d = byte_done;

        cs_n_d     = !((state_d == S_SETUP) || (state_d == S_SHIFT) ||
                       (state_d == S_WAIT)  || (state_d == S_HOLD));
        tx_ready_d = (state_d == S_IDLE) || (state_d == S_WAIT);
    end

    assign tx_ready = tx_ready_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign busy     = (state_q != S_IDLE);
    assign sclk     = sclk_q;
    assign cs_n     = cs_n_q;
    assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - scoreboard bench for spi_master (CLK_DIV=2 main instance, CLK_DIV=1 second instance)
module tb_spi_master;

    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_IDLE  = 2;
    localparam int D1_LOW   = CS_SETUP + 16 + CS_HOLD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       tx_valid = 1'b0, tx_last = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, rx_valid, busy, sclk, cs_n, mosi, miso;
    logic [7:0] rx_data;

    logic       tx2_valid = 1'b0;
    logic [7:0] tx2_data = 8'h00;
    logic       tx2_ready, rx2_valid, busy2, sclk2, cs2_n, mosi2;
    logic [7:0] rx2_data;

    spi_master #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)) u_dut (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_last(tx_last), .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .sclk(sclk),
        .cs_n(cs_n), .mosi(mosi), .miso(miso));

    spi_master #(.CLK_DIV(1), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx2_valid), .tx_ready(tx2_ready), .tx_data(tx2_data),
        .tx_last(1'b1), .rx_valid(rx2_valid), .rx_data(rx2_data), .busy(busy2), .sclk(sclk2),
        .cs_n(cs2_n), .mosi(mosi2), .miso(mosi2));

    int checks = 0, errors = 0;
    logic [7:0] rx_exp[$], mosi_exp[$], rx2_exp[$];
    int acc_total = 0;

    // miso source: 0 loopback, 1 mode-0 slave returning slave_val, 2 stuck high, 3 stuck low
    int mode = 0;
    logic [7:0] slave_val = 8'h00, slave_sr = 8'h00;
    logic slv_prev = 1'b0;

    always_comb begin
        case (mode)
            0:       miso = mosi;
            1:       miso = slave_sr[7];
            2:       miso = 1'b1;
            default: miso = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (cs_n) slave_sr = slave_val;
        else if (slv_prev && !sclk) slave_sr = {slave_sr[6:0], 1'b0};
        slv_prev = sclk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    function automatic logic [7:0] model_rx(input logic [7:0] d);
        case (mode)
            0:       return d;
            1:       return slave_val;
            2:       return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
        int n = 0;
        repeat (gap) begin @(posedge clk); #1; end
        tx_valid = 1'b1; tx_data = d; tx_last = last;
        while (!tx_ready && n < 3000) begin @(posedge clk); #1; n++; end
        if (n >= 3000) begin
            timeout("tx_accept");
            tx_valid = 1'b0;
            return;
        end
        rx_exp.push_back(model_rx(d));
        mosi_exp.push_back(d);
        @(posedge clk); #1;
        acc_total++;
        tx_valid = 1'b0; tx_data = 8'($urandom); tx_last = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || !tx_ready || rx_exp.size() != 0) && n < 5000) begin @(posedge clk); #1; n++; end
        if (n >= 5000) timeout("wait_idle");
    endtask

    task automatic send2(input logic [7:0] d);
        int n = 0;
        tx2_valid = 1'b1; tx2_data = d;
        while (!tx2_ready && n < 3000) begin @(posedge clk); #1; n++; end
        if (n >= 3000) begin
            timeout("tx2_accept");
            tx2_valid = 1'b0;
            return;
        end
        rx2_exp.push_back(d);
        @(posedge clk); #1;
        tx2_valid = 1'b0;
    endtask

    task automatic wait_idle2();
        int n = 0;
        while ((busy2 || !tx2_ready || rx2_exp.size() != 0) && n < 5000) begin @(posedge clk); #1; n++; end
        if (n >= 5000) timeout("wait_idle2");
    endtask

    // Monitor for the main instance: received bytes, mosi bit order, burst framing.
    int bit_idx = 0, rst_hold = 0, low_cnt = 0, wait_cnt = 0, rise_cnt = 0, burst_start = 0, gap_cnt = 0;
    logic in_burst = 1'b0, gap_active = 1'b0, p_sclk = 1'b0, p_cs_n = 1'b1;
    logic [7:0] cur_tx = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) rst_hold = 2;
        else if (rst_hold > 0) rst_hold--;
        if (rst_hold > 0) begin
            bit_idx = 0; in_burst = 1'b0; gap_active = 1'b0;
        end else begin
            if (rx_valid) begin
                if (rx_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rx_unexpected actual=0x%0h required=none", rx_data);
                end else begin
                    chk("rx_data", int'(rx_data), int'(rx_exp.pop_front()));
                end
            end
            if (sclk && !p_sclk) begin
                if (bit_idx == 0) begin
                    if (mosi_exp.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL sclk_rise_unexpected actual=rise required=none");
                        cur_tx = 8'h00;
                    end else begin
                        cur_tx = mosi_exp.pop_front();
                    end
                end
                chk("mosi_bit", int'(mosi), int'(cur_tx[7-bit_idx]));
                bit_idx = (bit_idx + 1) % 8;
            end
            if (p_cs_n && !cs_n) begin
                in_burst = 1'b1; burst_start = acc_total - 1;
                low_cnt = 0; wait_cnt = 0; rise_cnt = 0; gap_active = 1'b0;
            end
            if (!cs_n) begin
                low_cnt++;
                if (tx_ready) wait_cnt++;
                if (sclk && !p_sclk) rise_cnt++;
            end
            if (!p_cs_n && cs_n && in_burst) begin
                chk("burst_rises", rise_cnt, 8 * (acc_total - burst_start));
                chk("cs_low_cycles", low_cnt,
                    CS_SETUP + (acc_total - burst_start) * 16 * CLK_DIV + wait_cnt + CS_HOLD);
                in_burst = 1'b0; gap_active = 1'b1; gap_cnt = 0;
            end
            if (gap_active) begin
                if (tx_ready) begin
                    chk("cs_idle_gap_min", int'(gap_cnt >= CS_IDLE), 1);
                    gap_active = 1'b0;
                end else if (cs_n) begin
                    gap_cnt++;
                end
            end
        end
        p_sclk = sclk; p_cs_n = cs_n;
    end

    int low2 = 0, rise2 = 0;
    logic p_s2 = 1'b0, p_c2 = 1'b1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx2_valid) begin
                if (rx2_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rx2_unexpected actual=0x%0h required=none", rx2_data);
                end else begin
                    chk("div1_rx_data", int'(rx2_data), int'(rx2_exp.pop_front()));
                end
            end
            if (!cs2_n) begin
                low2++;
                if (sclk2 && !p_s2) rise2++;
            end
            if (!p_c2 && cs2_n) begin
                chk("div1_cs_low_cycles", low2, D1_LOW);
                chk("div1_rises", rise2, 8);
                low2 = 0; rise2 = 0;
            end
        end
        p_s2 = sclk2; p_c2 = cs2_n;
    end

    initial begin
        int n, r;
        logic p;
        int nb;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sclk", int'(sclk), 0);
        chk("rst_cs_n", int'(cs_n), 1);
        chk("rst_mosi", int'(mosi), 0);
        chk("rst_rx_valid", int'(rx_valid), 0);
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tx_ready", int'(tx_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", int'(tx_ready), 1);

        // single byte loopback
        mode = 0;
        send_byte(8'hA5, 1'b1, 0);
        wait_idle();

        // back-to-back burst
        send_byte(8'h12, 1'b0, 0);
        send_byte(8'h34, 1'b1, 0);
        wait_idle();

        // burst with the second byte held back in WAIT
        send_byte(8'h66, 1'b0, 0);
        n = 0;
        while (!rx_valid && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) timeout("wait_entry");
        for (int i = 0; i < 10; i++) begin
            chk("wait_sclk", int'(sclk), 0);
            chk("wait_cs_n", int'(cs_n), 0);
            chk("wait_tx_ready", int'(tx_ready), 1);
            @(posedge clk); #1;
        end
        send_byte(8'h99, 1'b1, 0);
        wait_idle();

        // reset after the third sclk rise
        send_byte(8'h3C, 1'b1, 0);
        p = sclk; n = 0; r = 0;
        while (r < 3 && n < 500) begin
            @(posedge clk); #1;
            if (sclk && !p) r++;
            p = sclk; n++;
        end
        if (r < 3) timeout("third_rise");
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_cs_n", int'(cs_n), 1);
        chk("abort_sclk", int'(sclk), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_rx_valid", int'(rx_valid), 0);
        chk("abort_mosi", int'(mosi), 0);
        rst_n = 1'b1;
        rx_exp.delete();
        mosi_exp.delete();
        @(posedge clk); #1;
        repeat (3) begin @(posedge clk); #1; end
        send_byte(8'h5A, 1'b1, 0);
        wait_idle();

        // slave model and stuck miso
        mode = 1; slave_val = 8'hC3;
        send_byte(8'h0F, 1'b1, 0);
        wait_idle();
        mode = 2;
        send_byte(8'h21, 1'b1, 0);
        wait_idle();
        mode = 3;
        send_byte(8'hE7, 1'b1, 0);
        wait_idle();

        // randomized bursts
        repeat (12) begin
            mode = $urandom_range(0, 3);
            slave_val = 8'($urandom);
            nb = (mode == 1) ? 1 : $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                send_byte(8'($urandom), (b == nb - 1), $urandom_range(0, 3));
            end
            wait_idle();
        end

        // CLK_DIV=1 instance
        send2(8'h81);
        wait_idle2();
        repeat (3) begin
            send2(8'($urandom));
            wait_idle2();
        end

        chk("rx_queue_drained", rx_exp.size(), 0);
        chk("rx2_queue_drained", rx2_exp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
